// File: rtl/mem_access_ctrl_if.sv
// Request / write-data / read-data handshake bundle between the processor
// control FSM (master) and the memory access controller (slave).
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 3
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              done;
    logic              busy;

    modport master (
        output req_valid, req_wr, req_addr, req_len, wr_valid, wr_data,
        input  req_ready, wr_ready, rd_valid, rd_data, done, busy
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_len, wr_valid, wr_data,
        output req_ready, wr_ready, rd_valid, rd_data, done, busy
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory access controller: turns single/multi-beat read or write requests
// into sigon-framed accesses on a word-addressed memory. Address, data and
// write-enable are only ever changed on edges that leave sigon low.
module mem_access_ctrl #(
    parameter int ADDR_W        = 5,
    parameter int DATA_W        = 32,
    parameter int LEN_W         = 3,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_ctrl_if.slave  host,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_datain,
    output logic              mem_sigwr,
    output logic              mem_sigon,
    input  logic [DATA_W-1:0] mem_dataout
);

    localparam int WAIT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state_q;
    logic               wr_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   beat_q;
    logic [WAIT_W-1:0]  wait_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  datain_q;
    logic [DATA_W-1:0]  rd_data_q;
    logic               sigwr_q;
    logic               sigon_q;
    logic               rd_valid_q;
    logic               done_q;

    logic [ADDR_W-1:0]  addr_d;
    logic [LEN_W-1:0]   beat_d;
    logic               last_beat_d;
    logic               last_wait_d;

    // Next-beat address (wraps naturally at 2^ADDR_W) and end-of-beat/burst flags
    always_comb begin
        addr_d      = addr_q + ADDR_W'(1);
        beat_d      = beat_q + LEN_W'(1);
        last_beat_d = (beat_q == len_q);
        last_wait_d = (wait_q == WAIT_LAST);
    end

    assign host.req_ready = (state_q == IDLE);
    assign host.busy      = (state_q != IDLE);
    // Write words are only taken while parked in SETUP of a write burst
    assign host.wr_ready  = (state_q == SETUP) && wr_q && host.wr_valid;
    assign host.rd_valid  = rd_valid_q;
    assign host.rd_data   = rd_data_q;
    assign host.done      = done_q;

    assign mem_addr   = addr_q;
    assign mem_datain = datain_q;
    assign mem_sigwr  = sigwr_q;
    assign mem_sigon  = sigon_q;

    // Burst sequencer with registered memory-side and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_q       <= 1'b0;
            len_q      <= '0;
            beat_q     <= '0;
            wait_q     <= '0;
            addr_q     <= '0;
            datain_q   <= '0;
            rd_data_q  <= '0;
            sigwr_q    <= 1'b0;
            sigon_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (host.req_valid) begin
                        wr_q    <= host.req_wr;
                        len_q   <= host.req_len;
                        beat_q  <= '0;
                        wait_q  <= '0;
                        addr_q  <= host.req_addr;
                        sigwr_q <= host.req_wr;
                        sigon_q <= 1'b0;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    // Reads go straight through; writes wait for a data word
                    if (!wr_q) begin
                        sigon_q <= 1'b1;
                        wait_q  <= '0;
                        state_q <= ACCESS;
                    end else if (host.wr_valid) begin
                        datain_q <= host.wr_data;
                        sigon_q  <= 1'b1;
                        wait_q   <= '0;
                        state_q  <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (last_wait_d) begin
                        sigon_q <= 1'b0;
                        if (!wr_q) begin
                            rd_data_q  <= mem_dataout;
                            rd_valid_q <= 1'b1;
                        end
                        if (last_beat_d) begin
                            sigwr_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            addr_q  <= addr_d;
                            beat_q  <= beat_d;
                            state_q <= SETUP;
                        end
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                DONE: begin
                    sigon_q <= 1'b0;
                    sigwr_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: one instance with single-cycle access
// and one with three-cycle access, each attached to a behavioural memory.
module tb_mem_access_ctrl;

    logic clk;
    logic rst;

    int n_cmp;
    int n_err;

    mem_access_ctrl_if #(.ADDR_W(5), .DATA_W(32), .LEN_W(3)) b1 ();
    mem_access_ctrl_if #(.ADDR_W(5), .DATA_W(32), .LEN_W(3)) b3 ();

    logic [4:0]  m1_addr, m3_addr;
    logic [31:0] m1_datain, m3_datain;
    logic [31:0] m1_dataout, m3_dataout;
    logic        m1_sigwr, m3_sigwr, m1_sigon, m3_sigon;

    logic [31:0] mem1 [32];
    logic [31:0] mem3 [32];

    logic [31:0] wdata [8];
    logic [4:0]  addr_log [$];
    logic [31:0] rd_log [$];

    int stab_err;
    logic [4:0]  p1_addr, p3_addr;
    logic [31:0] p1_data, p3_data;
    logic        p1_wr, p3_wr, p1_on, p3_on;

    mem_access_ctrl #(.ADDR_W(5), .DATA_W(32), .LEN_W(3), .ACCESS_CYCLES(1)) u_dut1 (
        .clk         (clk),
        .rst         (rst),
        .host        (b1),
        .mem_addr    (m1_addr),
        .mem_datain  (m1_datain),
        .mem_sigwr   (m1_sigwr),
        .mem_sigon   (m1_sigon),
        .mem_dataout (m1_dataout)
    );

    mem_access_ctrl #(.ADDR_W(5), .DATA_W(32), .LEN_W(3), .ACCESS_CYCLES(3)) u_dut3 (
        .clk         (clk),
        .rst         (rst),
        .host        (b3),
        .mem_addr    (m3_addr),
        .mem_datain  (m3_datain),
        .mem_sigwr   (m3_sigwr),
        .mem_sigon   (m3_sigon),
        .mem_dataout (m3_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memories: write on an enabled edge, asynchronous read
    always @(posedge clk) begin
        if (m1_sigon && m1_sigwr) mem1[m1_addr] <= m1_datain;
        if (m3_sigon && m3_sigwr) mem3[m3_addr] <= m3_datain;
    end
    assign m1_dataout = mem1[m1_addr];
    assign m3_dataout = mem3[m3_addr];

    // Memory-side stability: nothing may move while sigon stays high
    initial begin
        stab_err = 0;
        p1_on = 1'b0; p3_on = 1'b0;
        p1_addr = '0; p3_addr = '0; p1_data = '0; p3_data = '0;
        p1_wr = 1'b0; p3_wr = 1'b0;
    end
    always @(negedge clk) begin
        if (m1_sigon && p1_on && (m1_addr != p1_addr || m1_datain != p1_data || m1_sigwr != p1_wr))
            stab_err++;
        if (m3_sigon && p3_on && (m3_addr != p3_addr || m3_datain != p3_data || m3_sigwr != p3_wr))
            stab_err++;
        p1_on = m1_sigon; p1_addr = m1_addr; p1_data = m1_datain; p1_wr = m1_sigwr;
        p3_on = m3_sigon; p3_addr = m3_addr; p3_data = m3_datain; p3_wr = m3_sigwr;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One burst on the single-cycle instance. stall withholds wr_valid for
    // that many cycles after acceptance; rst_beat>0 pulses rst once that
    // many sigon pulses have been seen; poke keeps a bogus request asserted.
    task automatic run_burst1(input logic wr, input logic [4:0] addr, input logic [2:0] len,
                              input int stall, input int rst_beat, input logic poke,
                              output int done_cyc);
        int   cyc, idx, st, rises, wrr_bad, bad;
        logic prev_on, consumed, done_seen, rst_hit;
        addr_log.delete();
        rd_log.delete();
        done_cyc = -1; cyc = 0; idx = 0; st = stall; rises = 0; wrr_bad = 0;
        prev_on = 1'b0; done_seen = 1'b0; rst_hit = 1'b0;
        @(negedge clk);
        check_eq("req_ready_idle", 64'(b1.req_ready), 64'd1);
        b1.req_valid = 1'b1;
        b1.req_wr    = wr;
        b1.req_addr  = addr;
        b1.req_len   = len;
        @(posedge clk); #1;
        b1.req_valid = poke;
        b1.req_wr    = ~wr;
        b1.req_addr  = addr + 5'd3;
        b1.req_len   = 3'd0;
        while (!done_seen && !rst_hit && cyc < 200) begin
            if (!wr) begin
                b1.wr_valid = 1'b1;
                b1.wr_data  = 32'hBAD0BAD0;
            end else if (idx <= int'(len) && st == 0) begin
                b1.wr_valid = 1'b1;
                b1.wr_data  = wdata[idx];
            end else begin
                b1.wr_valid = 1'b0;
            end
            @(negedge clk);
            consumed = b1.wr_ready;
            if (!wr && b1.wr_ready) wrr_bad++;
            if (st > 0) begin
                check_eq("stall_sigon", 64'(m1_sigon), 64'd0);
                check_eq("stall_wr_ready", 64'(b1.wr_ready), 64'd0);
            end
            if (m1_sigon && !prev_on) begin
                addr_log.push_back(m1_addr);
                rises++;
            end
            prev_on = m1_sigon;
            if (b1.rd_valid) rd_log.push_back(b1.rd_data);
            if (b1.done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                b1.req_valid = 1'b0;
                check_eq("rd_valid_with_done", 64'(b1.rd_valid), 64'(!wr));
            end
            if (rst_beat > 0 && rises == rst_beat) begin
                rst_hit = 1'b1;
                rst = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
            if (consumed) idx++;
            if (st > 0) st--;
        end
        b1.wr_valid  = 1'b0;
        b1.req_valid = 1'b0;
        if (!wr) check_eq("wr_ready_on_read", 64'(wrr_bad), 64'd0);
        if (rst_hit) begin
            rst = 1'b0;
            @(negedge clk);
            check_eq("sigon_after_rst", 64'(m1_sigon), 64'd0);
            check_eq("busy_after_rst", 64'(b1.busy), 64'd0);
            bad = 0;
            repeat (6) begin
                @(negedge clk);
                if (b1.done || m1_sigon) bad++;
            end
            check_eq("quiet_after_rst", 64'(bad), 64'd0);
            @(posedge clk); #1;
        end else begin
            @(negedge clk);
            check_eq("idle_after_burst", 64'(b1.busy), 64'd0);
            @(posedge clk); #1;
        end
        $display("burst1 wr=%0d addr=%0d len=%0d stall=%0d done_cyc=%0d pulses=%0d", wr, addr, len, stall, done_cyc, rises);
    endtask

    // Single-beat burst on the three-cycle instance
    task automatic run3(input logic wr, input logic [4:0] addr, input logic [31:0] data,
                        output int done_cyc, output int on_cnt, output int rises);
        int   cyc;
        logic prev_on, done_seen;
        done_cyc = -1; on_cnt = 0; rises = 0; cyc = 0; prev_on = 1'b0; done_seen = 1'b0;
        @(negedge clk);
        b3.req_valid = 1'b1;
        b3.req_wr    = wr;
        b3.req_addr  = addr;
        b3.req_len   = 3'd0;
        b3.wr_valid  = wr;
        b3.wr_data   = data;
        @(posedge clk); #1;
        b3.req_valid = 1'b0;
        while (!done_seen && cyc < 100) begin
            @(negedge clk);
            if (m3_sigon) on_cnt++;
            if (m3_sigon && !prev_on) rises++;
            prev_on = m3_sigon;
            if (b3.done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        b3.wr_valid = 1'b0;
        $display("burst3 wr=%0d addr=%0d done_cyc=%0d sigon_cycles=%0d", wr, addr, done_cyc, on_cnt);
    endtask

    initial begin
        int dc, on_cnt, rises;
        n_cmp = 0;
        n_err = 0;
        b1.req_valid = 1'b0; b1.req_wr = 1'b0; b1.req_addr = '0; b1.req_len = '0;
        b1.wr_valid = 1'b0; b1.wr_data = '0;
        b3.req_valid = 1'b0; b3.req_wr = 1'b0; b3.req_addr = '0; b3.req_len = '0;
        b3.wr_valid = 1'b0; b3.wr_data = '0;
        for (int i = 0; i < 8; i++) wdata[i] = '0;

        // Reset for two cycles
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_req_ready", 64'(b1.req_ready), 64'd1);
        check_eq("rst_busy", 64'(b1.busy), 64'd0);
        check_eq("rst_sigon", 64'(m1_sigon), 64'd0);
        check_eq("rst_sigwr", 64'(m1_sigwr), 64'd0);
        check_eq("rst_mem_addr", 64'(m1_addr), 64'd0);
        check_eq("rst_mem_datain", 64'(m1_datain), 64'd0);
        check_eq("rst_rd_data", 64'(b1.rd_data), 64'd0);
        check_eq("rst_rd_valid", 64'(b1.rd_valid), 64'd0);
        check_eq("rst_done", 64'(b1.done), 64'd0);
        check_eq("rst3_busy", 64'(b3.busy), 64'd0);
        @(posedge clk); #1;

        // Single write then read back at address 5
        wdata[0] = 32'hDEADBEEF;
        run_burst1(1'b1, 5'd5, 3'd0, 0, 0, 1'b0, dc);
        check_eq("w1_done_cyc", 64'(dc), 64'd2);
        check_eq("w1_pulses", 64'(addr_log.size()), 64'd1);
        if (addr_log.size() > 0) check_eq("w1_addr", 64'(addr_log[0]), 64'd5);
        check_eq("w1_mem5", 64'(mem1[5]), 64'hDEADBEEF);
        check_eq("w1_rd_data_kept", 64'(b1.rd_data), 64'd0);
        run_burst1(1'b0, 5'd5, 3'd0, 0, 0, 1'b0, dc);
        check_eq("r1_done_cyc", 64'(dc), 64'd2);
        check_eq("r1_rd_count", 64'(rd_log.size()), 64'd1);
        check_eq("r1_rd_data", 64'(b1.rd_data), 64'hDEADBEEF);

        // Four-beat write and read wrapping 30,31,0,1
        for (int i = 0; i < 4; i++) wdata[i] = 32'(i + 1);
        run_burst1(1'b1, 5'd30, 3'd3, 0, 0, 1'b0, dc);
        check_eq("w4_done_cyc", 64'(dc), 64'd8);
        check_eq("w4_pulses", 64'(addr_log.size()), 64'd4);
        if (addr_log.size() == 4) begin
            check_eq("w4_addr0", 64'(addr_log[0]), 64'd30);
            check_eq("w4_addr1", 64'(addr_log[1]), 64'd31);
            check_eq("w4_addr2", 64'(addr_log[2]), 64'd0);
            check_eq("w4_addr3", 64'(addr_log[3]), 64'd1);
        end
        check_eq("w4_mem30", 64'(mem1[30]), 64'd1);
        check_eq("w4_mem1", 64'(mem1[1]), 64'd4);
        run_burst1(1'b0, 5'd30, 3'd3, 0, 0, 1'b1, dc);
        check_eq("r4_done_cyc", 64'(dc), 64'd8);
        check_eq("r4_pulses", 64'(addr_log.size()), 64'd4);
        check_eq("r4_rd_count", 64'(rd_log.size()), 64'd4);
        if (rd_log.size() == 4) begin
            for (int i = 0; i < 4; i++) check_eq("r4_rd_word", 64'(rd_log[i]), 64'(i + 1));
        end

        // Write stalled three cycles in SETUP
        wdata[0] = 32'hCAFEF00D;
        run_burst1(1'b1, 5'd9, 3'd0, 3, 0, 1'b0, dc);
        check_eq("ws_done_cyc", 64'(dc), 64'd5);
        check_eq("ws_mem9", 64'(mem1[9]), 64'hCAFEF00D);

        // Three-cycle access: write then read address 7
        run3(1'b1, 5'd7, 32'h12345678, dc, on_cnt, rises);
        check_eq("a3w_done_cyc", 64'(dc), 64'd4);
        run3(1'b0, 5'd7, 32'h0, dc, on_cnt, rises);
        check_eq("a3r_done_cyc", 64'(dc), 64'd4);
        check_eq("a3r_sigon_cycles", 64'(on_cnt), 64'd3);
        check_eq("a3r_sigon_pulses", 64'(rises), 64'd1);
        check_eq("a3r_rd_data", 64'(b3.rd_data), 64'h12345678);

        // Seed 12..15, then reset during the second beat of an overwrite
        for (int i = 0; i < 4; i++) wdata[i] = 32'hA0 + 32'(i);
        run_burst1(1'b1, 5'd12, 3'd3, 0, 0, 1'b0, dc);
        check_eq("seed_done_cyc", 64'(dc), 64'd8);
        for (int i = 0; i < 4; i++) wdata[i] = 32'h1000 + 32'(i);
        run_burst1(1'b1, 5'd12, 3'd3, 0, 2, 1'b0, dc);
        check_eq("rb_no_done", 64'(dc), 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("rb_mem12", 64'(mem1[12]), 64'h1000);
        check_eq("rb_mem13", 64'(mem1[13]), 64'h1001);
        check_eq("rb_mem14", 64'(mem1[14]), 64'hA2);
        check_eq("rb_mem15", 64'(mem1[15]), 64'hA3);
        check_eq("rb_rd_data_cleared", 64'(b1.rd_data), 64'd0);

        check_eq("sigon_stability", 64'(stab_err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the word-addressed data memory interface (addr/datain/dataout/sigwr/sigon).
- Accepts single- or multi-beat read/write requests from the processor control FSM.
- Sequences the memory control lines so address, data and write-enable change only while sigon is low, and returns read data and a completion pulse.
- Sits between the control unit / datapath and the memory.

Parameters:
- ADDR_W, 5, memory word-address width (32 words)
- DATA_W, 32, data word width
- LEN_W, 3, burst length field width; a burst is req_len+1 beats (1..8)
- ACCESS_CYCLES, 1, cycles mem_sigon is held high per beat (>=1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request (high only in IDLE)
- req_wr  in  1  1=write burst, 0=read burst
- req_addr  in  ADDR_W  start word address
- req_len  in  LEN_W  beats minus one
- wr_valid  in  1  write-data word present
- wr_data  in  DATA_W  write-data word
- wr_ready  out  1  write word consumed this cycle
- rd_valid  out  1  rd_data holds a new read word (one-cycle pulse per beat)
- rd_data  out  DATA_W  read word
- done  out  1  one-cycle pulse, burst complete
- busy  out  1  high in any state except IDLE
- mem_addr  out  ADDR_W  to memory addr
- mem_datain  out  DATA_W  to memory datain
- mem_sigwr  out  1  to memory sigwr
- mem_sigon  out  1  to memory sigon
- mem_dataout  in  DATA_W  from memory dataout

Behaviour:
- Reset (sync, rst=1 at edge):
  - state=IDLE
  - mem_sigon=0, mem_sigwr=0, mem_addr=0, mem_datain=0
  - rd_data=0, rd_valid=0, done=0, busy=0
  - beat and wait counters = 0
  - Reset mid-burst aborts the burst; mem_sigon is low the cycle after the reset edge. No further beats are issued and no done pulse is produced.
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid: latch req_wr, req_addr, req_len; beat=0 -> SETUP.
- SETUP:
  - mem_sigon=0.
  - mem_addr=current address; mem_sigwr=latched wr.
  - Read: -> ACCESS next cycle.
  - Write: wr_ready=wr_valid (combinational). On wr_valid, register wr_data into mem_datain and go -> ACCESS. Otherwise stay in SETUP, stalling indefinitely.
- ACCESS:
  - mem_sigon=1 for exactly ACCESS_CYCLES cycles; mem_addr, mem_datain and mem_sigwr are held stable.
  - On the last cycle:
    - Read: register mem_dataout into rd_data; rd_valid pulses the following cycle.
    - Then, if beat==len -> DONE; else address+1 (mod 2^ADDR_W, so 31 wraps to 0), beat+1 -> SETUP.
- DONE:
  - mem_sigon=0, mem_sigwr=0, done=1 for one cycle -> IDLE.
  - req_ready returns high the cycle after done.
- Latency:
  - With no write stalls, done is high exactly (len+1)*(ACCESS_CYCLES+1) cycles after the accepting edge.
  - The last beat's rd_valid coincides with done.
- mem_sigon is low for at least one cycle between beats. The memory never sees an address or data change while enabled.
- req_valid while busy is ignored; the request is not queued.
- wr_valid during a read burst, or outside SETUP, is ignored; wr_ready stays 0.
- req_wr, req_addr and req_len changes after acceptance have no effect.
- rd_data holds its last value between pulses and is unchanged by write bursts.

Test Plan:
- Reset with rst=1 for 2 cycles -> all outputs 0, req_ready=1, busy=0.
- Single write, ACCESS_CYCLES=1: addr=5, len=0, wr_data=0xDEADBEEF with wr_valid held -> one sigon pulse at addr 5 with sigwr=1; done 2 cycles after accept. A following read of addr 5 gives rd_data=0xDEADBEEF, with rd_valid and done coincident.
- 4-beat write then 4-beat read starting at addr 30, data 1,2,3,4 -> mem_addr sequence 30,31,0,1. rd_data reads back 1,2,3,4 with four rd_valid pulses. sigon is low between beats.
- Write stall: wr_valid withheld for 3 cycles in SETUP -> mem_sigon stays 0 and wr_ready stays 0. The burst resumes the cycle after wr_valid rises. done is 3 cycles later than the unstalled case.
- ACCESS_CYCLES=3 single read -> sigon high for exactly 3 consecutive cycles; done 4 cycles after accept.
- rst asserted during beat 2 of a 4-beat write -> sigon=0 the next cycle, no done, addresses 2..3 of the burst unchanged in memory. A req_valid during a busy burst is not accepted.
